sgd_scalar_broadcast: RTL and testbench

Inverse of the SGD adder tree: accepts one signed 32-bit scalar per handshake (e.g. the scaled error/gradient factor produced after the dot-product reduction) and fans it out to `TREE_WIDTH` bank lanes through a registered binary fan-out tree. Each accepted scalar is re-emitted `repeat_count` times, one beat per feature chunk, so every bank can apply it across its model slice. The block sits between the reduction/loss stage and the per-bank model-update units.

---
 rtl/sgd_bcast_pkg.sv | 23 ++
 rtl/sgd_bcast_fanout.sv | 57 +++++
 rtl/sgd_scalar_broadcast.sv | 97 +++++++++
 tb/tb_sgd_scalar_broadcast.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sgd_bcast_pkg.sv
// Shared types and helpers for the SGD scalar broadcast block.
// Rounding shift is used only when SGD_BCAST_SHIFT_EN is defined.
package sgd_bcast_pkg;

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  localparam int CNT_W = 16;

  function automatic logic signed [31:0] round_shift(
    input logic signed [31:0] x,
    input logic [4:0]         k
  );
    logic signed [32:0] t;
    logic signed [32:0] r;
    t = $signed({x[31], x}) + (33'sd1 <<< (k - 5'd1));
    r = t >>> k;
    return (k == 5'd0) ? x : r[31:0];
  endfunction

endpackage

// File: rtl/sgd_bcast_fanout.sv
// Registered binary fan-out tree; stage d holds 2**d copies.
// Nodes are heap-ordered: node n loads its parent (n-1)/2.
module sgd_bcast_fanout
  import sgd_bcast_pkg::*;
#(
  parameter int TREE_DEPTH = 3,
  parameter int W          = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic signed [W-1:0] in_data,
  input  logic                in_valid,
  input  logic                in_last,
  input  logic                out_ready,
  output logic                en,
  output logic                any_valid,
  output logic signed [W-1:0] out_data [2**TREE_DEPTH],
  output logic                out_valid,
  output logic                out_last
);

  localparam int LANES = 2**TREE_DEPTH;
  localparam int NODES = 2*LANES - 1;

  logic signed [W-1:0] node [NODES];
  logic [TREE_DEPTH:0] vld;
  logic [TREE_DEPTH:0] lst;

  assign en        = out_ready || !vld[TREE_DEPTH];
  assign any_valid = |vld;
  assign out_valid = vld[TREE_DEPTH];
  assign out_last  = lst[TREE_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NODES; n++) node[n] <= '0;
    end else if (en) begin
      node[0] <= in_data;
      for (int n = 1; n < NODES; n++) node[n] <= node[(n-1)/2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      lst <= '0;
    end else if (en) begin
      vld <= {vld[TREE_DEPTH-1:0], in_valid};
      lst <= {lst[TREE_DEPTH-1:0], in_last && in_valid};
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) out_data[i] = node[LANES-1+i];
  end

endmodule

// File: rtl/sgd_scalar_broadcast.sv
// Broadcasts one scalar to all bank lanes, repeat_count beats per scalar.
// Define SGD_BCAST_SHIFT_EN to apply a rounding arithmetic right shift.
module sgd_scalar_broadcast
  import sgd_bcast_pkg::*;
#(
  parameter int TREE_DEPTH = 3,
  parameter int TREE_WIDTH = 2**TREE_DEPTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [31:0] s_input,
  input  logic               s_input_valid,
  output logic               s_input_ready,
  input  logic [15:0]        repeat_count,
  input  logic [4:0]         step_shift,
  output logic signed [31:0] v_output [TREE_WIDTH],
  output logic               v_output_valid,
  output logic               v_output_last,
  input  logic               v_output_ready,
  output logic               busy
);

  state_t state, state_nxt;

  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   num;
  logic signed [31:0] hold;
  logic signed [31:0] hold_nxt;
  logic               en;
  logic               any_valid;
  logic               accept;
  logic               emit;
  logic               last_beat;

  assign accept    = s_input_valid && s_input_ready;
  assign last_beat = (cnt == num - 16'd1);

`ifdef SGD_BCAST_SHIFT_EN
  assign hold_nxt = round_shift(s_input, step_shift);
`else
  logic unused_shift;
  assign unused_shift = ^step_shift;
  assign hold_nxt     = s_input;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      (state == IDLE): if (accept) state_nxt = EMIT;
      (state == EMIT): if (en && last_beat) state_nxt = IDLE;
      default:         state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_input_ready = (state == IDLE);
    emit          = (state == EMIT);
    busy          = (state != IDLE) || any_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= '0;
      num  <= '0;
      cnt  <= '0;
    end else if (accept) begin
      hold <= hold_nxt;
      num  <= (repeat_count == 16'd0) ? 16'd1 : repeat_count;
      cnt  <= '0;
    end else if (emit && en) begin
      cnt  <= cnt + 16'd1;
    end
  end

  sgd_bcast_fanout #(
    .TREE_DEPTH (TREE_DEPTH),
    .W          (32)
  ) u_fanout (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (hold),
    .in_valid  (emit),
    .in_last   (last_beat),
    .out_ready (v_output_ready),
    .en        (en),
    .any_valid (any_valid),
    .out_data  (v_output),
    .out_valid (v_output_valid),
    .out_last  (v_output_last)
  );

endmodule

// File: tb/tb_sgd_scalar_broadcast.sv
// Directed bench for sgd_scalar_broadcast with a queue-based beat model.
// Build with or without SGD_BCAST_SHIFT_EN to match the RTL build.
module tb_sgd_scalar_broadcast;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [31:0] s_input = '0;
  logic               s_input_valid = 1'b0;
  logic               s_input_ready;
  logic [15:0]        repeat_count = '0;
  logic [4:0]         step_shift = '0;
  logic signed [31:0] v_output [8];
  logic               v_output_valid;
  logic               v_output_last;
  logic               v_output_ready = 1'b1;
  logic               busy;

  always #5 clk = ~clk;

  sgd_scalar_broadcast dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_input        (s_input),
    .s_input_valid  (s_input_valid),
    .s_input_ready  (s_input_ready),
    .repeat_count   (repeat_count),
    .step_shift     (step_shift),
    .v_output       (v_output),
    .v_output_valid (v_output_valid),
    .v_output_last  (v_output_last),
    .v_output_ready (v_output_ready),
    .busy           (busy)
  );

  typedef struct {
    logic signed [31:0] d;
    logic               l;
  } beat_t;

  beat_t q[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int beats, last_cnt, last_pos, acc_cyc, first_cyc, ready_low;
  logic signed [31:0] first_d;

  function automatic logic signed [31:0] model_val(
    input logic signed [31:0] x,
    input logic [4:0] k
  );
`ifdef SGD_BCAST_SHIFT_EN
    longint v;
    if (k == 5'd0) return x;
    v = longint'(x) + (longint'(1) <<< (int'(k) - 1));
    v = v >>> k;
    return 32'(v);
`else
    return x + 32'sd0 * k;
`endif
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: queue one expected beat per repeat at accept, pop on transfer.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      cyc++;
      if (s_input_valid && s_input_ready) begin
        int n;
        n = (repeat_count == 16'd0) ? 1 : int'(repeat_count);
        for (int i = 0; i < n; i++)
          q.push_back('{model_val(s_input, step_shift), i == n - 1});
        acc_cyc = cyc;
      end
      if (v_output_valid && v_output_ready) begin
        if (beats == 0) begin
          first_cyc = cyc;
          first_d   = v_output[0];
        end
        if (v_output_last) begin
          last_cnt++;
          last_pos = beats;
        end
        beats++;
        if (q.size() > 0) void'(q.pop_front());
      end
      if (!s_input_ready) ready_low++;
    end
  end

  logic               stall_prev = 1'b0;
  logic signed [31:0] prev_d [8];
  logic               prev_l;

  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev) begin
        tests++;
        if (!v_output_valid || v_output != prev_d || v_output_last != prev_l) begin
          fails++;
          $display("FAIL stall_hold: valid=%0b lane0=%0d last=%0b held lane0=%0d last=%0b",
                   v_output_valid, v_output[0], v_output_last, prev_d[0], prev_l);
        end
      end
      if (v_output_valid) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL spurious_beat: lane0=%0d with no beat expected", v_output[0]);
        end else begin
          for (int i = 0; i < 8; i++) begin
            if (v_output[i] !== q[0].d) begin
              fails++;
              $display("FAIL lane_data: lane%0d=%0d expected %0d", i, v_output[i], q[0].d);
              break;
            end
          end
          if (v_output_last !== q[0].l) begin
            fails++;
            $display("FAIL last_flag: got %0b expected %0b", v_output_last, q[0].l);
          end
        end
      end
      stall_prev = v_output_valid && !v_output_ready;
      prev_d     = v_output;
      prev_l     = v_output_last;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic clear_stats();
    beats = 0; last_cnt = 0; last_pos = -1;
    acc_cyc = -100; first_cyc = -1; first_d = '0; ready_low = 0;
  endtask

  task automatic send(input logic signed [31:0] d, input logic [4:0] k,
                      input logic [15:0] n);
    bit done;
    done = 0;
    s_input = d; step_shift = k; repeat_count = n; s_input_valid = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      if (s_input_ready) done = 1;
      @(posedge clk); #1;
    end
    s_input_valid = 1'b0;
    if (!done) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_done();
    bit done;
    done = 0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(posedge clk); #1;
      if (q.size() == 0 && !busy && s_input_ready) done = 1;
    end
    if (!done) check("drain_timeout", 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic shift_case(input logic signed [31:0] d, input logic [4:0] k,
                            input logic signed [31:0] exp_on, input string name);
    logic signed [31:0] exp;
`ifdef SGD_BCAST_SHIFT_EN
    exp = exp_on;
`else
    exp = d;
`endif
    clear_stats();
    send(d, k, 16'd1);
    wait_done();
    check({name, "_beats"}, beats, 1);
    check({name, "_data"}, first_d, exp);
  endtask

  initial begin
    clear_stats();
    #2;
    tests++;
    if (v_output_valid !== 1'b0 || v_output_last !== 1'b0 || busy !== 1'b0 ||
        v_output[0] !== 32'sd0 || v_output[7] !== 32'sd0) begin
      fails++;
      $display("FAIL reset_outputs: valid=%0b last=%0b busy=%0b lane0=%0d",
               v_output_valid, v_output_last, busy, v_output[0]);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_ready", s_input_ready, 1);

    // Single beat: latency counted to the transferring edge.
    clear_stats();
    send(-32'sd7, 5'd0, 16'd1);
    wait_done();
    check("t1_beats", beats, 1);
    check("t1_data", first_d, -7);
    check("t1_last_cnt", last_cnt, 1);
    check("t1_latency", first_cyc - acc_cyc, 5);

    clear_stats();
    send(32'sd100, 5'd0, 16'd4);
    wait_done();
    check("t2_beats", beats, 4);
    check("t2_data", first_d, 100);
    check("t2_last_pos", last_pos, 3);
    check("t2_last_cnt", last_cnt, 1);
    check("t2_ready_low", ready_low, 4);
    check("t2_latency", first_cyc - acc_cyc, 5);

    // Backpressure with ready pattern 1,0,0,1,0,1 once data arrives.
    begin
      bit seen;
      logic pat [6];
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      seen = 0;
      clear_stats();
      v_output_ready = 1'b0;
      send(32'sd21, 5'd0, 16'd3);
      for (int t = 0; t < 20 && !seen; t++) begin
        if (v_output_valid) seen = 1;
        else begin @(posedge clk); #1; end
      end
      check("t3_valid_seen", seen, 1);
      for (int i = 0; i < 6; i++) begin
        v_output_ready = pat[i];
        @(posedge clk); #1;
      end
      v_output_ready = 1'b1;
      wait_done();
      check("t3_beats", beats, 3);
      check("t3_data", first_d, 21);
      check("t3_last_pos", last_pos, 2);
    end

    clear_stats();
    send(32'sd9, 5'd0, 16'd0);
    wait_done();
    check("t4_beats", beats, 1);
    check("t4_data", first_d, 9);
    check("t4_last_cnt", last_cnt, 1);

    shift_case(32'sd13, 5'd2, 32'sd3, "sh_13_2");
    shift_case(-32'sd13, 5'd2, -32'sd3, "sh_m13_2");
    shift_case(-32'sd14, 5'd2, -32'sd3, "sh_m14_2");
    shift_case(32'sh7FFFFFFF, 5'd1, 32'sh40000000, "sh_max_1");
    shift_case(32'sd5, 5'd0, 32'sd5, "sh_5_0");

    // Two scalars offered back to back.
    clear_stats();
    send(32'sd11, 5'd0, 16'd2);
    send(-32'sd300, 5'd0, 16'd3);
    wait_done();
    check("t5_beats", beats, 5);
    check("t5_last_cnt", last_cnt, 2);

    // Reset with beats in flight, then confirm nothing stale appears.
    clear_stats();
    v_output_ready = 1'b0;
    send(32'sd55, 5'd0, 16'd6);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (v_output_valid !== 1'b0 || v_output_last !== 1'b0 || busy !== 1'b0 ||
        v_output[3] !== 32'sd0) begin
      fails++;
      $display("FAIL mid_reset: valid=%0b last=%0b busy=%0b lane3=%0d",
               v_output_valid, v_output_last, busy, v_output[3]);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    v_output_ready = 1'b1;
    @(posedge clk); #1;
    check("post_reset_ready", s_input_ready, 1);
    clear_stats();
    repeat (12) @(posedge clk);
    #1;
    check("post_reset_beats", beats, 0);

    clear_stats();
    send(32'sd77, 5'd0, 16'd2);
    wait_done();
    check("t6_beats", beats, 2);
    check("t6_data", first_d, 77);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
